instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage downstream of the instruction-cycle controller. On the controller's fetch
//  strobe it reads one instruction word from program memory over a req/ack handshake,
//  latches it into the instruction register (IR) for decode, and advances the PC.
//  Accepts PC redirects (branch/jump) from execute; flags a memory timeout.
// PARAMETERS
//  ADDR_W   8   PC / memory address width
//  DATA_W   16  instruction word width
//  RESET_PC 0   PC value after reset
//  TIMEOUT  15  max cycles in REQ without mem_ack before error (1..255)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       asynchronous, active-high
//  fetch_en       in   1       fetch strobe from cycle controller (1-cycle pulse)
//  branch_valid   in   1       redirect PC request from execute
//  branch_target  in   ADDR_W  redirect address
//  mem_req        out  1       program-memory read request
//  mem_addr       out  ADDR_W  read address, stable while mem_req=1
//  mem_ack        in   1       memory accepts and returns mem_rdata this cycle
//  mem_rdata      in   DATA_W  instruction word, valid when mem_ack=1
//  ir             out  DATA_W  instruction register
//  ir_valid       out  1       1-cycle pulse: ir updated
//  pc             out  ADDR_W  address of next instruction to fetch
//  busy           out  1       1 while state != IDLE (stall hint for controller)
//  fetch_err      out  1       sticky timeout flag
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, ir=0, ir_valid=0, mem_req=0, mem_addr=0,
//   busy=0, fetch_err=0, timeout count=0, pending branch cleared. Mid-request reset aborts
//   the request; mem_req drops immediately.
//  States: IDLE, REQ, ERR (encoded in package).
//  IDLE: fetch_en=1 -> REQ; mem_addr <= (branch_valid ? branch_target : pc); count=0.
//   branch_valid without fetch_en -> pc <= branch_target, stay IDLE.
//  REQ: mem_req=1. mem_ack=1 -> ir<=mem_rdata, ir_valid=1 next cycle, -> IDLE;
//   pc <= pending branch target if one was latched, else mem_addr+1.
//   mem_ack=0 -> count+1; count reaches TIMEOUT -> ERR.
//   branch_valid in REQ: latch target as pending (last one wins); current fetch completes
//   and its IR is still delivered. fetch_en in REQ/ERR ignored.
//  ERR: mem_req=0, fetch_err=1, busy=1; only reset exits.
//  Latency: fetch_en at cycle N -> mem_req at N+1; mem_ack sampled at cycle M ->
//   ir/ir_valid/pc updated, mem_req=0 at M+1. Minimum fetch_en-to-ir_valid = 2 cycles.
//  Width rules: pc increment is modulo 2^ADDR_W (max -> 0), no carry out; count is
//   8 bits, saturates.
//  Simultaneous fetch_en+branch_valid in IDLE: branch wins as fetch address; pc ends
//   at branch_target+1.
//  mem_ack outside REQ is ignored.
// STRUCTURE
//  Package fetch_pkg: state localparams (IDLE=2'b00, REQ=2'b01, ERR=2'b10), default
//   ADDR_W/DATA_W shared with cycle controller and decoder.
//  Sub-module fetch_timeout_timer: clear/enable/expired counter, parameter TIMEOUT.
//  Remainder (FSM, PC, IR, pending-branch regs) in this module.
// TESTING
//  Reset, mem ack same cycle as req, rdata=16'hA5C3 at pc=0 -> mem_req 1 cycle,
//   ir=16'hA5C3, ir_valid 1 cycle, pc=1.
//  Ack delayed 3 cycles -> mem_addr held stable 4 cycles, busy=1 throughout, pc 5->6.
//  fetch_en+branch_valid target 8'h40 in IDLE -> mem_addr=8'h40, pc=8'h41 after ack.
//  branch_valid target 8'h10 during REQ at pc=3 -> IR of addr 3 delivered, pc=8'h10.
//  pc=8'hFF fetch -> pc wraps to 8'h00.
//  No ack for 15 cycles -> ERR, fetch_err=1 sticky, mem_req=0; async reset mid-REQ
//   clears all outputs without waiting for clk.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and default widths for the fetch stage, the
//               cycle controller and the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Default bus widths shared with the cycle controller and decoder
  localparam int unsigned DEFAULT_ADDR_W = 8;
  localparam int unsigned DEFAULT_DATA_W = 16;

  // Width of the request timeout counter; it saturates rather than wrapping
  localparam int unsigned COUNT_W = 8;

  // Fetch FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    ERR  = 2'b10
  } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_if
// Description : Program-memory read channel (req/ack handshake). The fetch
//               unit is the master; program memory is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface : instruction_fetch_unit_if
`default_nettype wire

// File: rtl/instruction_fetch_unit_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_timeout_timer
// Description : Counts unanswered request cycles. 'expired' is raised in the
//               enabled cycle that would bring the count up to TIMEOUT, so
//               the FSM leaves REQ after exactly TIMEOUT cycles without ack.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_timeout_timer
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(TIMEOUT - 1);
  localparam logic [COUNT_W-1:0] ONE  = COUNT_W'(1);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  // Next count: clear wins, otherwise count up while enabled and saturate
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q >= LAST);

endmodule : fetch_timeout_timer
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch stage. On a fetch strobe reads one instruction word
//               over the req/ack channel, loads the IR, advances the PC,
//               honours branch redirects and flags a memory timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  input  logic                     branch_valid,
  input  logic [ADDR_W-1:0]        branch_target,
  instruction_fetch_unit_if.master mem,
  output logic [DATA_W-1:0]        ir,
  output logic                     ir_valid,
  output logic [ADDR_W-1:0]        pc,
  output logic                     busy,
  output logic                     fetch_err
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  fetch_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // FSM next state plus PC / IR / pending-branch updates
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    ir_d          = ir_q;
    ir_valid_d    = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    timer_clear   = 1'b0;
    timer_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (fetch_en) begin
          // A simultaneous redirect becomes the fetch address itself
          state_d      = REQ;
          addr_d       = branch_valid ? branch_target : pc_q;
          timer_clear  = 1'b1;
          pend_valid_d = 1'b0;
        end else if (branch_valid) begin
          pc_d = branch_target;
        end
      end

      REQ: begin
        if (mem.mem_ack) begin
          state_d      = IDLE;
          ir_d         = mem.mem_rdata;
          ir_valid_d   = 1'b1;
          pend_valid_d = 1'b0;
          // A redirect arriving with the ack is the most recent, so it wins
          if (branch_valid) begin
            pc_d = branch_target;
          end else if (pend_valid_q) begin
            pc_d = pend_target_q;
          end else begin
            pc_d = addr_q + PC_STEP;
          end
        end else begin
          timer_en = 1'b1;
          if (branch_valid) begin
            pend_valid_d  = 1'b1;
            pend_target_d = branch_target;
          end
          if (timer_expired) begin
            state_d = ERR;
          end
        end
      end

      ERR: begin
        // Terminal until reset
        state_d = ERR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= PC_INIT;
      addr_q        <= '0;
      ir_q          <= '0;
      ir_valid_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      ir_q          <= ir_d;
      ir_valid_q    <= ir_valid_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Status outputs decode straight from the state flop so reset drops them at once
  assign mem.mem_req  = (state_q == REQ);
  assign mem.mem_addr = addr_q;
  assign busy         = (state_q != IDLE);
  assign fetch_err    = (state_q == ERR);
  assign ir           = ir_q;
  assign ir_valid     = ir_valid_q;
  assign pc           = pc_q;

endmodule : instruction_fetch_unit
`default_nettype wire
